// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
// Holds the grant-owner enum and the default address/data widths.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DBG  = 2'd2
    } gnt_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Saturating starvation counter for the debug requester.
// Ports: clk, rst (sync, high), inc, clr (clr wins), at_max (count == STARVE_MAX).
module dm_arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAX = CW'(STARVE_MAX);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign at_max = (r_cnt == MAX);

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single data-memory port between the MEM stage (priority)
// and a debug/loader requester, with a starvation guarantee for debug.
// Ports: clk, rst (sync, high); cpu_req/we/addr/wdata -> cpu_rdata, cpu_stall;
//   dbg_req/we/addr/wdata -> dbg_ack, dbg_err, dbg_rdata, dbg_rvalid;
//   Mem_w, Mem_r, Mem_addr, Mem_w_data -> DM, Mem_r_data <- DM.
// Optional: define DM_ARB_ALIGN_CHECK_EN to reject misaligned debug addresses.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic              Mem_w,
    output logic              Mem_r,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [DATA_W-1:0] Mem_w_data,
    input  logic [DATA_W-1:0] Mem_r_data
);

    gnt_t              w_gnt;
    logic              w_at_max;
    logic              w_misalign;
    logic              w_dbg_slot;
    logic              w_dbg_go;
    logic              w_dbg_rd;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    always_comb begin
        w_gnt = GNT_NONE;
        if (rst) begin
            w_gnt = GNT_NONE;
        end else if (w_at_max && dbg_req) begin
            w_gnt = GNT_DBG;
        end else if (cpu_req) begin
            w_gnt = GNT_CPU;
        end else if (dbg_req) begin
            w_gnt = GNT_DBG;
        end
    end

`ifdef DM_ARB_ALIGN_CHECK_EN
    assign w_misalign = |dbg_addr[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    // A rejected debug request still consumes the debug slot.
    assign w_dbg_slot = (w_gnt == GNT_DBG);
    assign w_dbg_go   = w_dbg_slot & ~w_misalign;
    assign w_dbg_rd   = w_dbg_go & ~dbg_we;

    always_comb begin
        Mem_r      = 1'b0;
        Mem_w      = 1'b0;
        Mem_addr   = '0;
        Mem_w_data = '0;
        unique case (w_gnt)
            GNT_CPU: begin
                Mem_r      = ~cpu_we;
                Mem_w      = cpu_we;
                Mem_addr   = cpu_addr;
                Mem_w_data = cpu_wdata;
            end
            GNT_DBG: begin
                if (!w_misalign) begin
                    Mem_r      = ~dbg_we;
                    Mem_w      = dbg_we;
                    Mem_addr   = dbg_addr;
                    Mem_w_data = dbg_wdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign cpu_rdata = Mem_r_data;
    assign cpu_stall = w_dbg_slot & cpu_req;
    assign dbg_ack   = w_dbg_go;
    assign dbg_err   = w_dbg_slot & w_misalign;

    dm_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    ((w_gnt == GNT_CPU) & dbg_req),
        .clr    (w_dbg_slot | ~dbg_req),
        .at_max (w_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_dbg_rd;
            if (w_dbg_rd) begin
                r_rdata <= Mem_r_data;
            end
        end
    end

    assign dbg_rvalid = r_rvalid;
    assign dbg_rdata  = r_rdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter with a behavioural data memory.
// Build with +define+DM_ARB_ALIGN_CHECK_EN to exercise the alignment check.
module tb_dm_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack, dbg_err, dbg_rvalid;
    logic        Mem_w, Mem_r;
    logic [31:0] Mem_addr, Mem_w_data, Mem_r_data;

    logic [31:0] mem [0:255];

    int n_chk = 0;
    int n_err = 0;
    logic exp_rv = 1'b0;
    logic [31:0] sb_q[$];

    dm_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_err    (dbg_err),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid),
        .Mem_w      (Mem_w),
        .Mem_r      (Mem_r),
        .Mem_addr   (Mem_addr),
        .Mem_w_data (Mem_w_data),
        .Mem_r_data (Mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory, preloaded while reset is asserted.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h04] <= 32'hDEADBEEF;
            mem[8'h0C] <= 32'hA5A5A5A5;
            mem[8'h10] <= 32'hCAFEF00D;
        end else if (Mem_w) begin
            mem[Mem_addr[9:2]] <= Mem_w_data;
        end
    end

    always_comb Mem_r_data = mem[Mem_addr[9:2]];

    typedef struct {
        logic        creq, cwe;
        logic [31:0] caddr, cwd;
        logic        dreq, dwe;
        logic [31:0] daddr, dwd;
        logic        er, ew;
        logic [31:0] eaddr, ewd;
        logic        estall, eack, eerr;
        logic        crdchk;
        logic [31:0] ecrd;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
        logic dreq, logic dwe, logic [31:0] daddr, logic [31:0] dwd,
        logic er, logic ew, logic [31:0] eaddr, logic [31:0] ewd,
        logic estall, logic eack, logic eerr,
        logic crdchk, logic [31:0] ecrd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        v.er = er; v.ew = ew; v.eaddr = eaddr; v.ewd = ewd;
        v.estall = estall; v.eack = eack; v.eerr = eerr;
        v.crdchk = crdchk; v.ecrd = ecrd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rv();
        chk("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, exp_rv});
        if (exp_rv && sb_q.size() > 0) begin
            chk("dbg_rdata", dbg_rdata, sb_q.pop_front());
        end
    endtask

    task automatic drive(vec_t v);
        cpu_req = v.creq; cpu_we = v.cwe;
        cpu_addr = v.caddr; cpu_wdata = v.cwd;
        dbg_req = v.dreq; dbg_we = v.dwe;
        dbg_addr = v.daddr; dbg_wdata = v.dwd;
    endtask

    // Inputs change 1 after posedge; outputs compared at mid-cycle.
    task automatic step(vec_t v, string tag);
        drive(v);
        #3;
        check_rv();
        chk({tag, ".Mem_r"}, {31'b0, Mem_r}, {31'b0, v.er});
        chk({tag, ".Mem_w"}, {31'b0, Mem_w}, {31'b0, v.ew});
        chk({tag, ".Mem_addr"}, Mem_addr, v.eaddr);
        chk({tag, ".Mem_w_data"}, Mem_w_data, v.ewd);
        chk({tag, ".cpu_stall"}, {31'b0, cpu_stall}, {31'b0, v.estall});
        chk({tag, ".dbg_ack"}, {31'b0, dbg_ack}, {31'b0, v.eack});
        chk({tag, ".dbg_err"}, {31'b0, dbg_err}, {31'b0, v.eerr});
        if (v.crdchk) chk({tag, ".cpu_rdata"}, cpu_rdata, v.ecrd);
        exp_rv = v.eack & ~v.dwe;
        if (exp_rv) sb_q.push_back(mem[v.daddr[9:2]]);
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(string tag);
        chk({tag, ".Mem_r"}, {31'b0, Mem_r}, 32'h0);
        chk({tag, ".Mem_w"}, {31'b0, Mem_w}, 32'h0);
        chk({tag, ".Mem_addr"}, Mem_addr, 32'h0);
        chk({tag, ".dbg_ack"}, {31'b0, dbg_ack}, 32'h0);
        chk({tag, ".dbg_err"}, {31'b0, dbg_err}, 32'h0);
        chk({tag, ".cpu_stall"}, {31'b0, cpu_stall}, 32'h0);
    endtask

    initial begin
        vec_t idle, both_cpu, both_dbg, mis;
        idle = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
        both_cpu = mk(1,0,32'h40,0, 1,0,32'h30,0,
                      1,0,32'h40,0, 0,0,0, 1,32'hCAFEF00D);
        both_dbg = mk(1,0,32'h40,0, 1,0,32'h30,0,
                      1,0,32'h30,0, 1,1,0, 0,0);
`ifdef DM_ARB_ALIGN_CHECK_EN
        mis = mk(0,0,0,0, 1,1,32'h21,32'h55, 0,0,0,0, 0,0,1, 0,0);
`else
        mis = mk(0,0,0,0, 1,1,32'h21,32'h55, 0,1,32'h21,32'h55, 0,1,0, 0,0);
`endif
        tv.push_back(mk(1,0,32'h10,0, 0,0,0,0, 1,0,32'h10,0, 0,0,0,
                        1,32'hDEADBEEF));
        tv.push_back(mk(0,0,0,0, 1,1,32'h20,32'h12345678,
                        0,1,32'h20,32'h12345678, 0,1,0, 0,0));
        tv.push_back(idle);
        tv.push_back(mk(1,0,32'h20,0, 0,0,0,0, 1,0,32'h20,0, 0,0,0,
                        1,32'h12345678));
        tv.push_back(mk(0,0,0,0, 1,0,32'h30,0, 1,0,32'h30,0, 0,1,0, 0,0));
        tv.push_back(idle);
        tv.push_back(idle);
        for (int i = 0; i < 4; i++) tv.push_back(both_cpu);
        tv.push_back(both_dbg);
        tv.push_back(both_cpu);
        tv.push_back(idle);
        tv.push_back(mis);
        tv.push_back(idle);

        rst = 1'b1;
        drive(both_cpu);
        #2;
        check_quiet("rst0");
        @(posedge clk); #1;
        chk("rst.dbg_rvalid", {31'b0, dbg_rvalid}, 32'h0);
        chk("rst.dbg_rdata", dbg_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rv = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i], $sformatf("v%0d", i));
        end

        // Reset lands in the cycle a forced debug grant is due.
        for (int i = 0; i < 4; i++) step(both_cpu, $sformatf("pre%0d", i));
        drive(both_cpu);
        rst = 1'b1;
        #3;
        check_quiet("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rv = 1'b0;
        step(both_cpu, "post0");
        step(idle, "post1");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
